// File: rtl/slow_domain_rx_pkg.sv
// Shared defaults for the slow-clock receiver: data width, FIFO depth, watchdog
// timeout and the synchronizer/phase constants the edge detector relies on.
package slow_domain_rx_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int DEPTH_DEF      = 4;
  localparam int TIMEOUT_DEF    = 16;
  localparam int SYNC_STAGES    = 3;
  // Shortest slow_clock high or low phase, in fast cycles, that is never missed.
  localparam int MIN_SLOW_PHASE = 3;

endpackage

// File: rtl/slow_domain_rx_fifo.sv
// Circular FIFO with a registered head word: push-to-visible 1 cycle, no bypass.
// Full push without a same-cycle pop is dropped and latches a sticky overflow.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              ovf_q, ovf_d;
  logic              full, do_pop, do_push;

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign head_o     = head_q;
  assign overflow_o = ovf_q;

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full | do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    head_d  = head_q;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push) wr_d = wr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (push_i && !do_push) ovf_d = 1'b1;
    // The next head is the word being written right now when it lands in the head slot.
    if (cnt_d != '0) begin
      if (do_push && (rd_d == wr_q)) head_d = push_data_i;
      else                           head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) mem_q[wr_q] <= push_data_i;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/slow_domain_rx.sv
// Samples slow_clock as data, captures slow_data on its rising edge into a FIFO
// (out_valid 3 clk edges after the rise) and flags a stalled slow_clock.
module slow_domain_rx
  import slow_domain_rx_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clock,
  input  logic              slow_valid,
  input  logic [DATA_W-1:0] slow_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              edge_rise,
  output logic              overflow,
  output logic              clock_lost
);

  localparam int WD_MAX = (TIMEOUT > MIN_SLOW_PHASE) ? TIMEOUT : MIN_SLOW_PHASE;
  localparam int WD_W   = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   fall;
  logic                   fifo_empty;

  // Edges are decoded from the two oldest stages so both pulses are glitch-free.
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], slow_clock};
  assign edge_rise  = sync_q[1] & ~sync_q[2];
  assign fall       = ~sync_q[1] & sync_q[2];
  assign clock_lost = (wd_q == WD_LIMIT);
  assign out_valid  = ~fifo_empty;

  always_comb begin
    wd_d = wd_q;
    if (edge_rise || fall) wd_d = '0;
    else if (wd_q != WD_LIMIT) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      wd_q   <= '0;
    end else begin
      sync_q <= sync_d;
      wd_q   <= wd_d;
    end
  end

  // slow_valid/slow_data are stable for the whole slow period, so direct sampling is safe.
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (edge_rise & slow_valid),
    .push_data_i (slow_data),
    .pop_i       (out_ready),
    .head_o      (out_data),
    .empty_o     (fifo_empty),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_slow_domain_rx.sv
// Directed, table-driven bench for slow_domain_rx: one table row per 8-cycle slow period.
module tb_slow_domain_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clock, slow_valid, out_ready;
  logic [7:0] slow_data, out_data;
  logic       out_valid, edge_rise, overflow, clock_lost;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slow_domain_rx #(
    .DATA_W  (8),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slow_clock (slow_clock),
    .slow_valid (slow_valid),
    .slow_data  (slow_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .edge_rise  (edge_rise),
    .overflow   (overflow),
    .clock_lost (clock_lost)
  );

  // rdy: 0 = out_ready low, 1 = high all period, 2 = high only for the capture edge
  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [1:0] rdy;
    logic       exp_vld3;
    logic [7:0] exp_head3;
    logic       exp_ov;
  } vec_t;

  vec_t       tbl [18];
  logic [7:0] exp_t3 [4];
  logic [7:0] exp_t2 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; slow_clock = 1'b0; slow_valid = 1'b0; slow_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_out_valid"},  out_valid,  0);
    chk({tag, "_out_data"},   out_data,   0);
    chk({tag, "_edge_rise"},  edge_rise,  0);
    chk({tag, "_overflow"},   overflow,   0);
    chk({tag, "_clock_lost"}, clock_lost, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_period(input int n, input vec_t v);
    int edges = 0;
    int epos  = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        slow_clock = 1'b1; slow_valid = v.vld; slow_data = v.dat; out_ready = (v.rdy == 2'd1);
      end
      if (i == 4) slow_clock = 1'b0;
      if (v.rdy == 2'd2) out_ready = (i == 2);
      @(negedge clk);
      if (edge_rise) begin
        edges++;
        if (epos < 0) epos = i;
      end
      if (i == 3) begin
        chk($sformatf("p%0d_out_valid", n), out_valid, v.exp_vld3);
        chk($sformatf("p%0d_out_data", n),  out_data,  v.exp_head3);
      end
      if (i == 7) begin
        chk($sformatf("p%0d_overflow", n),   overflow,   v.exp_ov);
        chk($sformatf("p%0d_clock_lost", n), clock_lost, 0);
      end
    end
    chk($sformatf("p%0d_edge_count", n), edges, 1);
    chk($sformatf("p%0d_edge_pos", n),   epos,  2);
  endtask

  task automatic drain(input logic [7:0] w [4], input string tag);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      chk($sformatf("%s_w%0d_valid", tag, k), out_valid, 1);
      chk($sformatf("%s_w%0d_data", tag, k),  out_data,  w[k]);
    end
    @(negedge clk);
    chk({tag, "_empty_after"}, out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stale;
    tbl[0]  = '{1'b1, 8'h00, 2'd1, 1'b1, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 2'd1, 1'b1, 8'h01, 1'b0};
    tbl[2]  = '{1'b1, 8'h02, 2'd1, 1'b1, 8'h02, 1'b0};
    tbl[3]  = '{1'b1, 8'h03, 2'd1, 1'b1, 8'h03, 1'b0};
    tbl[4]  = '{1'b0, 8'h04, 2'd1, 1'b0, 8'h03, 1'b0};
    tbl[5]  = '{1'b1, 8'h05, 2'd1, 1'b1, 8'h05, 1'b0};
    tbl[6]  = '{1'b0, 8'h06, 2'd1, 1'b0, 8'h05, 1'b0};
    tbl[7]  = '{1'b1, 8'h20, 2'd0, 1'b1, 8'h20, 1'b0};
    tbl[8]  = '{1'b1, 8'h21, 2'd0, 1'b1, 8'h20, 1'b0};
    tbl[9]  = '{1'b1, 8'h22, 2'd0, 1'b1, 8'h20, 1'b0};
    tbl[10] = '{1'b1, 8'h23, 2'd0, 1'b1, 8'h20, 1'b0};
    tbl[11] = '{1'b1, 8'h24, 2'd2, 1'b1, 8'h21, 1'b0};
    tbl[12] = '{1'b1, 8'h30, 2'd0, 1'b1, 8'h30, 1'b0};
    tbl[13] = '{1'b1, 8'h31, 2'd0, 1'b1, 8'h30, 1'b0};
    tbl[14] = '{1'b1, 8'h32, 2'd0, 1'b1, 8'h30, 1'b0};
    tbl[15] = '{1'b1, 8'h33, 2'd0, 1'b1, 8'h30, 1'b0};
    tbl[16] = '{1'b1, 8'h34, 2'd0, 1'b1, 8'h30, 1'b1};
    tbl[17] = '{1'b1, 8'h35, 2'd0, 1'b1, 8'h30, 1'b1};
    exp_t3 = '{8'h21, 8'h22, 8'h23, 8'h24};
    exp_t2 = '{8'h30, 8'h31, 8'h32, 8'h33};

    rst = 1'b1; slow_clock = 1'b0; slow_valid = 1'b0; slow_data = 8'h00; out_ready = 1'b0;
    do_reset("rst0");

    // Streaming, alternate-valid periods, then fill and a full-FIFO pop+capture.
    for (int n = 0; n < 12; n++) run_period(n, tbl[n]);
    drain(exp_t3, "t3");

    do_reset("rst1");
    for (int n = 12; n < 18; n++) run_period(n, tbl[n]);
    drain(exp_t2, "t2");
    chk("t2_overflow_sticky", overflow, 1);

    // Stalled slow_clock, then restart with captures while clock_lost is high.
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t5_lost_after_stall", clock_lost, 1);
    @(posedge clk); #1;
    slow_clock = 1'b1; slow_valid = 1'b1; slow_data = 8'h55; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t5_restart_edge", edge_rise, 1);
    chk("t5_lost_at_edge", clock_lost, 1);
    @(negedge clk);
    chk("t5_lost_cleared", clock_lost, 0);
    chk("t5_capture_valid", out_valid, 1);
    chk("t5_capture_data", out_data, 8'h55);
    @(posedge clk); #1;
    slow_clock = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    slow_clock = 1'b1; slow_data = 8'h56;
    repeat (4) @(posedge clk);
    #1;
    slow_clock = 1'b0; slow_valid = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t5_lost_k%0d", k), clock_lost, (k >= 19));
    end
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_head", out_data, 8'h55);
    chk("t6_pre_overflow", overflow, 1);

    // Asynchronous reset between clock edges with two words queued.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_overflow", overflow, 0);
    chk("t6_async_lost", clock_lost, 0);
    chk("t6_async_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("t6_no_stale_word", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slow_domain_rx.md
Name: slow_domain_rx

Overview:
- Receives words launched in the divided (slow) clock domain and delivers them into the fast clk domain through a valid/ready FIFO interface.
- slow_clock is treated as data: it is synchronized, and its rising edge becomes a capture strobe.
- Also supervises slow_clock: a watchdog flags when slow_clock stops toggling.
- Sits between slow-domain producers (e.g. pixel/peripheral logic) and fast-domain consumers.

Parameters:
- DATA_W, 8: width of slow_data and out_data.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- TIMEOUT, 16: fast cycles without any slow_clock edge before clock_lost asserts; minimum 4.

Ports:
- clk  in  1  fast system clock; all state is clocked on its rising edge.
- rst  in  1  asynchronous active-high reset.
- slow_clock  in  1  divided clock, sampled as data.
- slow_valid  in  1  slow-domain qualifier; stable for a full slow period.
- slow_data  in  DATA_W  slow-domain word; stable for a full slow period.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head when out_valid is high.
- edge_rise  out  1  one-cycle pulse per detected slow_clock rising edge.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- clock_lost  out  1  watchdog expired.

Behaviour:
Interface (already decided):
- One clock, clk.
- rst is asynchronous and active-high.

Reset:
- All registers clear on rst high.
- Outputs during and after reset: out_valid=0, out_data=0, edge_rise=0, overflow=0, clock_lost=0.
- Sync chain, FIFO pointers, occupancy count and watchdog counter all clear.
- Reset mid-operation discards FIFO contents and any in-flight edge.

Synchronizer and edge detect:
- Chain s1 -> s2 -> s3 on clk; s1 samples slow_clock.
- edge_rise = s2 & ~s3. It is decoded from registers only and is never high for two consecutive cycles.
- Falling edge internally: fall = ~s2 & s3.
- Latency: slow_clock rises before edge E0 -> edge_rise high in the cycle after E1.
- Requirement on slow_clock: high and low phases are each at least 3 fast cycles. Shorter phases are unsupported and may miss edges.

Capture:
- In the cycle where edge_rise=1 and slow_valid=1, slow_data is written at the end of that cycle.
- slow_data and slow_valid are sampled directly, unsynchronized. This is safe because they are stable for the whole slow period and sampling occurs 2-3 fast cycles after launch.
- out_valid rises at E2, i.e. 3 fast edges after the slow_clock transition.

FIFO:
- Circular buffer, DEPTH entries, with a log2(DEPTH)+1 bit occupancy count.
- out_data shows the head entry whenever out_valid=1. It holds its last value when empty.
- Pop on out_valid & out_ready.
- Write when full with no pop in the same cycle: the word is dropped, the FIFO is unchanged, and overflow sets to 1 until rst.
- Full with a simultaneous pop and write: both occur. The count is unchanged and there is no overflow.
- Empty with a write: no bypass. out_valid appears the next cycle.
- Pointers wrap modulo DEPTH.

Watchdog:
- Counter clears on edge_rise or fall; otherwise it increments and saturates at TIMEOUT.
- clock_lost = (counter == TIMEOUT).
- clock_lost deasserts in the cycle after the next detected edge.
- Capture and the FIFO keep operating while clock_lost=1.

Decomposition:
Shared package holds:
- DATA_W, DEPTH and TIMEOUT defaults.
- Synchronizer stage count (3).
- Minimum slow phase constant (3).

Sub-modules:
- One sub-module, sync_fifo (DATA_W, DEPTH): push, pop, full, empty, overflow drop.
- Synchronizer, edge detect and watchdog stay in the top module.

Test Plan:
1. Reset, then slow_clock as an 8-cycle-period square wave with slow_valid=1 and slow_data incrementing 0x00,0x01,... per slow period; out_ready=1 -> words 0x00,0x01,0x02 appear in order, out_valid rises 3 edges after each slow rise, and edge_rise pulses exactly once per 8 cycles.
2. Same stimulus with out_ready=0 for 6 slow periods -> 4 words are held (0x00-0x03), overflow=1 after the 5th capture, and draining yields 0x00-0x03 only.
3. FIFO full with out_ready=1 in the same cycle as a capture -> occupancy stays 4, overflow stays 0, and ordering is preserved.
4. slow_valid=0 on alternate periods -> only words from valid periods are enqueued, and edge_rise still pulses every period.
5. slow_clock held low after running -> clock_lost=1 exactly TIMEOUT=16 cycles after the last detected edge; restarting slow_clock clears it the cycle after the next edge.
6. rst asserted asynchronously mid-burst with 2 words queued -> out_valid, overflow and clock_lost drop immediately, and no stale word appears after release.
